// File: rtl/intr_arbiter.sv
// Fixed-priority interrupt arbiter: latches source pulses into pending bits, applies a mask,
// and hands the lowest-numbered eligible source to the core via req/ack, eoi and a guard gap.
module intr_arbiter #(
  parameter int N_SRC      = 4,
  parameter int CW         = 2,
  parameter int GAP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_SRC-1:0] src_pulse,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ovr_clr,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq_req,
  output logic             irq_pulse,
  output logic [CW-1:0]    irq_cause,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t           state_r, state_nxt;
  logic [N_SRC-1:0] pending_r, mask_r, overrun_r;
  logic [N_SRC-1:0] eligible_s, clr_s;
  logic [CW-1:0]    cause_r, cause_nxt, win_s;
  logic             pulse_r, pulse_nxt;
  logic             ack_take_s;
  logic [7:0]       gap_r, gap_nxt;

  // Ack clear vector and lowest-index winner among unmasked pending sources
  always_comb begin
    ack_take_s = (state_r == REQ) & irq_ack;
    clr_s      = {N_SRC{1'b0}};
    eligible_s = pending_r & ~mask_r;
    win_s      = {CW{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      clr_s[i] = ack_take_s & (cause_r == CW'(i));
    end
    // Scan downward so the lowest set index is the last one written
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        win_s = CW'(i);
      end else begin
        win_s = win_s;
      end
    end
  end

  // Next-state and next-output decode for the request FSM
  always_comb begin
    state_nxt = state_r;
    cause_nxt = cause_r;
    pulse_nxt = 1'b0;
    gap_nxt   = gap_r;
    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          state_nxt = REQ;
          cause_nxt = win_s;
          pulse_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt = SERVICE;
        end else begin
          state_nxt = REQ;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_nxt = GAP;
          gap_nxt   = 8'(GAP_CYCLES);
        end else begin
          state_nxt = SERVICE;
        end
      end
      GAP: begin
        if (gap_r <= 8'd1) begin
          state_nxt = IDLE;
          gap_nxt   = 8'd0;
        end else begin
          state_nxt = GAP;
          gap_nxt   = gap_r - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gap_nxt   = 8'd0;
      end
    endcase
  end

  // FSM state, latched cause, request strobe and gap counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cause_r <= {CW{1'b0}};
      pulse_r <= 1'b0;
      gap_r   <= 8'd0;
    end else begin
      state_r <= state_nxt;
      cause_r <= cause_nxt;
      pulse_r <= pulse_nxt;
      gap_r   <= gap_nxt;
    end
  end

  // Pending, overrun and mask registers; a pulse beats its own ack-clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_r <= {N_SRC{1'b0}};
      overrun_r <= {N_SRC{1'b0}};
      mask_r    <= {N_SRC{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | src_pulse;
      overrun_r <= (overrun_r & ~{N_SRC{ovr_clr}}) | (src_pulse & pending_r & ~clr_s);
      if (mask_we) begin
        mask_r <= mask_wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  assign irq_req   = (state_r == REQ);
  assign irq_pulse = pulse_r;
  assign irq_cause = cause_r;
  assign pending   = pending_r;
  assign mask      = mask_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed test-plan scenarios followed by random traffic, every cycle compared against
// a timestamp-based behavioural model of the arbiter.
module tb_intr_arbiter;

  localparam int N   = 4;
  localparam int GAP = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] src_pulse, mask_wdata;
  logic         mask_we, ovr_clr, irq_ack, eoi;
  logic         irq_req, irq_pulse;
  logic [1:0]   irq_cause;
  logic [N-1:0] pending, mask, overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: request/service flags plus the earliest edge at which arbitration may occur
  logic [N-1:0] m_pend, m_mask, m_ovr;
  bit           m_req, m_svc, m_pulse;
  int           m_cause;
  longint       edge_no, idle_from;

  intr_arbiter #(.N_SRC(N), .CW(2), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .resetn(resetn), .src_pulse(src_pulse), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ovr_clr(ovr_clr), .irq_ack(irq_ack), .eoi(eoi),
    .irq_req(irq_req), .irq_pulse(irq_pulse), .irq_cause(irq_cause),
    .pending(pending), .mask(mask), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_ovr = '0;
    m_req = 1'b0; m_svc = 1'b0; m_pulse = 1'b0; m_cause = 0;
    edge_no = 0; idle_from = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] clrv, elig, np, no;
    int lowest;
    if (!resetn) begin
      model_reset();
      return;
    end
    edge_no++;
    clrv = '0;
    if (m_req && irq_ack) clrv[m_cause] = 1'b1;
    elig = m_pend & ~m_mask;
    np = (m_pend & ~clrv) | src_pulse;
    no = (ovr_clr ? 4'b0000 : m_ovr) | (src_pulse & m_pend & ~clrv);
    m_pulse = 1'b0;
    if (m_req) begin
      if (irq_ack) begin m_req = 1'b0; m_svc = 1'b1; end
    end else if (m_svc) begin
      if (eoi) begin m_svc = 1'b0; idle_from = edge_no + GAP + 1; end
    end else if (edge_no >= idle_from && elig != 0) begin
      lowest = -1;
      for (int i = 0; i < N; i++) if (lowest < 0 && elig[i]) lowest = i;
      m_req = 1'b1; m_pulse = 1'b1; m_cause = lowest;
    end
    if (mask_we) m_mask = mask_wdata;
    m_pend = np;
    m_ovr  = no;
  endtask

  task automatic check_all();
    check("irq_req",   32'(irq_req),   32'(m_req));
    check("irq_pulse", 32'(irq_pulse), 32'(m_pulse));
    check("irq_cause", 32'(irq_cause), 32'(m_cause));
    check("pending",   32'(pending),   32'(m_pend));
    check("mask",      32'(mask),      32'(m_mask));
    check("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    src_pulse = '0; mask_we = 1'b0; ovr_clr = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [N-1:0] p);
    src_pulse = p; tick(); src_pulse = '0;
  endtask

  task automatic ack_eoi_drain();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    idle(GAP + 2);
  endtask

  initial begin
    int n;
    resetn = 1'b0; src_pulse = '0; mask_we = 1'b0; mask_wdata = '0;
    ovr_clr = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    model_reset();
    idle(2);
    check("reset_pending", 32'(pending), 32'd0);
    resetn = 1'b1;
    idle(3);

    // Single source: request two cycles after the pulse, cleared by ack
    pulse(4'b0001);
    tick();
    check("single_req",   32'(irq_req),   32'd1);
    check("single_pulse", 32'(irq_pulse), 32'd1);
    check("single_cause", 32'(irq_cause), 32'd0);
    idle(2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("single_ack_req",  32'(irq_req), 32'd0);
    check("single_ack_pend", 32'(pending), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    idle(GAP + 2);

    // Priority and gap length
    pulse(4'b1010);
    tick();
    check("prio_cause1", 32'(irq_cause), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    n = 0;
    for (int k = 0; k < 30 && !irq_req; k++) begin tick(); n++; end
    check("gap_len",     32'(n),         32'(GAP + 1));
    check("prio_cause3", 32'(irq_cause), 32'd3);
    ack_eoi_drain();

    // Masking blocks selection but not latching
    mask_we = 1'b1; mask_wdata = 4'b0100; tick(); mask_we = 1'b0;
    pulse(4'b0100);
    idle(2);
    check("mask_pend", 32'(pending), 32'd4);
    check("mask_noreq", 32'(irq_req), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    check("unmask_req0", 32'(irq_req), 32'd0);
    tick();
    check("unmask_req1",  32'(irq_req),   32'd1);
    check("unmask_cause", 32'(irq_cause), 32'd2);
    ack_eoi_drain();

    // Overrun: double pulse, pulse coincident with ack, then clear
    pulse(4'b0001);
    pulse(4'b0001);
    check("ovr_set", 32'(overrun), 32'd1);
    tick();
    src_pulse = 4'b0001; irq_ack = 1'b1; tick(); src_pulse = '0; irq_ack = 1'b0;
    check("ovr_ackpend", 32'(pending), 32'd1);
    check("ovr_keep",    32'(overrun), 32'd1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    idle(GAP + 2);
    ack_eoi_drain();

    // Asynchronous reset while in SERVICE
    pulse(4'b0010);
    tick();
    src_pulse = 4'b1000; irq_ack = 1'b1; tick(); src_pulse = '0; irq_ack = 1'b0;
    #1 resetn = 1'b0;
    #1 model_reset();
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    check("rst_cause",   32'(irq_cause), 32'd0);
    check_all();
    tick();
    resetn = 1'b1;
    tick();
    check("rst_nopulse", 32'(irq_pulse), 32'd0);
    pulse(4'b0100);
    tick();
    check("rst_lat_req",   32'(irq_req),   32'd1);
    check("rst_lat_cause", 32'(irq_cause), 32'd2);
    ack_eoi_drain();

    // Spurious ack in IDLE and eoi in REQ
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("spur_ack_req", 32'(irq_req), 32'd0);
    pulse(4'b0001);
    tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("spur_eoi_req",  32'(irq_req), 32'd1);
    check("spur_eoi_pend", 32'(pending), 32'd1);
    ack_eoi_drain();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      src_pulse  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      mask_we    = ($urandom_range(0, 31) == 0);
      mask_wdata = 4'($urandom) & 4'($urandom);
      ovr_clr    = ($urandom_range(0, 15) == 0);
      irq_ack    = ($urandom_range(0, 2) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_arbiter.md
# intr_arbiter

Multi-source interrupt arbiter between the per-source `gen_inter_cycle` pulse shapers and the CPU core's interrupt input. It latches single-cycle interrupt pulses into pending bits and applies a software-writable mask. It selects the lowest-numbered unmasked pending source and presents it to the core through a request/acknowledge handshake. After the handler signals end-of-interrupt, a programmable guard gap elapses before the next request is issued.

## Interface
- `N_SRC`, default 4: number of interrupt sources, 2..16.
- `CW`, default 2: cause-ID width, equal to clog2(`N_SRC`).
- `GAP_CYCLES`, default 8: idle cycles enforced after `eoi`, 1..255.

- `clk` in 1: single clock. Same clock as the core (`clk_cpu`).
- `resetn` in 1: asynchronous, active-low reset.
- `src_pulse` in `N_SRC`: single-cycle interrupt pulses, one per source.
- `mask_we` in 1: write strobe for the mask register.
- `mask_wdata` in `N_SRC`: new mask value. 1 = source masked.
- `ovr_clr` in 1: clears all overrun flags.
- `irq_ack` in 1: core accepts the current request.
- `eoi` in 1: handler finished (core retires `eret`).
- `irq_req` out 1: request to core, level.
- `irq_pulse` out 1: one-cycle strobe on request start, for cores that take a pulse.
- `irq_cause` out `CW`: index of the source being requested or serviced.
- `pending` out `N_SRC`: latched pending bits.
- `mask` out `N_SRC`: current mask.
- `overrun` out `N_SRC`: sticky, set when a pulse arrives while that source's pending bit is already set.

## Operation
- **Reset values:** `pending`=0, `mask`=0 (all enabled), `overrun`=0, `irq_req`=0, `irq_pulse`=0, `irq_cause`=0, gap counter=0, state=IDLE.
- **Pending update** (per bit i, per cycle): next = (pending[i] & ~clr_i) | `src_pulse`[i].
  - clr_i is asserted when `irq_ack` is accepted in REQ and `irq_cause`==i.
  - A pulse coincident with its own clear leaves the bit set and does not flag overrun.
  - Pending bits latch regardless of mask. Masking only blocks selection.
- **Overrun:** set when `src_pulse`[i] & pending[i] & ~clr_i. Cleared by `ovr_clr`. If set and clear occur in the same cycle, set wins.
- **Mask write:** `mask` <= `mask_wdata` on `mask_we`. The new value takes effect for selection from the next cycle.
- **Selection:** eligible = `pending` & ~`mask`. The lowest set index wins (fixed priority, 0 highest).
- **FSM:**
  - IDLE:
    - If eligible != 0: latch `irq_cause` = winning index, go to REQ, assert `irq_pulse` for this transition.
  - REQ:
    - `irq_req`=1.
    - On `irq_ack`: clear pending[cause], go to SERVICE.
    - Masking the cause while in REQ does not withdraw the request; the request is committed.
  - SERVICE:
    - `irq_req`=0 and `irq_cause` is held.
    - On `eoi`: load gap counter with `GAP_CYCLES`, go to GAP.
  - GAP:
    - Counter decrements each cycle. When it reaches 0, go to IDLE.
    - Pulses during GAP still latch into `pending`.
- **Ignored inputs:** `irq_ack` outside REQ and `eoi` outside SERVICE have no effect.
- **Output source:** all outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

## Timing
- **Request latency:** pulse at cycle t → pending bit visible at t+1 → `irq_req`/`irq_pulse` high at t+2, provided the FSM is in IDLE at t+1.
- **`irq_pulse` width:** exactly 1 cycle, coincident with the first REQ cycle.
- **Ack timing:** ack sampled at edge e → `irq_req` low and pending bit cleared from e+1.
- **Back-to-back service:** after `eoi` sampled at edge e, the next `irq_req` can rise no earlier than e+`GAP_CYCLES`+1.
- **Asynchronous reset:** `resetn` low clears all state immediately. An in-flight request, service, or gap is abandoned, and no pulse is emitted on reset release.

## Test plan
- **Single source:** `src_pulse`=0001 at cycle 10 → `irq_req`=1, `irq_pulse`=1 at 12, `irq_cause`=0. Ack at 15 → `irq_req`=0 and `pending`=0000 at 16.
- **Priority and gap:** `src_pulse`=1010 in one cycle → cause 1 served first. After `eoi`, `GAP_CYCLES`=8 idle cycles pass, then `irq_req` rises with cause 3.
- **Masking:** mask=0100 written, then pulse on source 2 → `pending`=0100 and no `irq_req`. Write mask=0000 → `irq_req` two cycles later with cause 2.
- **Overrun:** two pulses on source 0 before ack → `overrun`=0001. A pulse in the same cycle as ack of cause 0 → `pending`[0] stays 1 and `overrun` is unchanged. `ovr_clr` → `overrun`=0000.
- **Reset mid-operation:** `resetn` low while in SERVICE → all outputs 0 immediately. After release, a new pulse is served with normal 2-cycle latency.
- **Spurious inputs:** `irq_ack` pulsed in IDLE and `eoi` pulsed in REQ → no state change, and `pending` is unchanged.
